alu: RTL and testbench



---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_core.sv | 85 ++++++++
 rtl/alu.sv | 70 +++++++
 tb/tb_alu.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, width and flag bundle for the RV32I ALU.
// Optional C/V flag logic is enabled with ALU_CV_FLAGS_EN.
package alu_pkg;

  localparam int ALU_W = 32;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1111;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } alu_flags_t;

  // Signed less-than built from sign bits and an unsigned compare,
  // so it is exact over the full range without using the SUB path.
  function automatic logic slt32(
    input logic [ALU_W-1:0] a,
    input logic [ALU_W-1:0] b
  );
    if (a[ALU_W-1] != b[ALU_W-1])
      return a[ALU_W-1];
    return (a < b);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational result and flag generator for the RV32I ALU.
// C/V logic exists only when ALU_CV_FLAGS_EN is defined.
module alu_core
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] i_a,
  input  logic [ALU_W-1:0] i_b,
  input  logic [3:0]       i_op,
  output logic [ALU_W-1:0] o_result,
  output alu_flags_t       o_flags
);

  logic [4:0]       w_shamt;
  logic [ALU_W:0]   w_add;
  logic [ALU_W:0]   w_sub;
  logic             w_slt;
  logic             w_sltu;
  logic [ALU_W-1:0] w_res;

  assign w_shamt = i_b[4:0];
  assign w_add   = {1'b0, i_a} + {1'b0, i_b};
  // Carry out of A + ~B + 1 is the inverted borrow.
  assign w_sub   = {1'b0, i_a} + {1'b0, ~i_b} + 33'd1;
  assign w_slt   = slt32(i_a, i_b);
  assign w_sltu  = (i_a < i_b);

  always_comb begin
    w_res = '0;
    case (i_op)
      ALU_ADD:  w_res = w_add[ALU_W-1:0];
      ALU_SUB:  w_res = w_sub[ALU_W-1:0];
      ALU_AND:  w_res = i_a & i_b;
      ALU_OR:   w_res = i_a | i_b;
      ALU_XOR:  w_res = i_a ^ i_b;
      ALU_SLL:  w_res = i_a << w_shamt;
      ALU_SRL:  w_res = i_a >> w_shamt;
      ALU_SRA:  w_res = $unsigned($signed(i_a) >>> w_shamt);
      ALU_SLT:  w_res = {{(ALU_W-1){1'b0}}, w_slt};
      ALU_SLTU: w_res = {{(ALU_W-1){1'b0}}, w_sltu};
      default:  w_res = '0;
    endcase
  end

  assign o_result  = w_res;
  assign o_flags.z = (w_res == '0);
  assign o_flags.n = w_res[ALU_W-1];

`ifdef ALU_CV_FLAGS_EN
  logic w_c;
  logic w_v;
  logic w_sa;
  logic w_sb;

  assign w_sa = i_a[ALU_W-1];
  assign w_sb = i_b[ALU_W-1];

  always_comb begin
    w_c = 1'b0;
    w_v = 1'b0;
    case (i_op)
      ALU_ADD: begin
        w_c = w_add[ALU_W];
        w_v = (w_sa == w_sb) &&
              (w_add[ALU_W-1] != w_sa);
      end
      ALU_SUB: begin
        w_c = w_sub[ALU_W];
        w_v = (w_sa != w_sb) &&
              (w_sub[ALU_W-1] != w_sa);
      end
      default: begin
        w_c = 1'b0;
        w_v = 1'b0;
      end
    endcase
  end

  assign o_flags.c = w_c;
  assign o_flags.v = w_v;
`else
  assign o_flags.c = 1'b0;
  assign o_flags.v = 1'b0;
`endif

endmodule

// File: rtl/alu.sv
// RV32I ALU top: alu_core followed by an async-reset output register.
// C_flag/V_flag registers exist only when ALU_CV_FLAGS_EN is defined.
module alu
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [ALU_W-1:0] A,
  input  logic [ALU_W-1:0] B,
  input  logic [3:0]       ALUControl,
  output logic [ALU_W-1:0] Result,
  output logic             Z_flag,
  output logic             N_flag,
  output logic             C_flag,
  output logic             V_flag
);

  logic [ALU_W-1:0] w_result;
  alu_flags_t       w_flags;

  logic [ALU_W-1:0] r_result;
  logic             r_z;
  logic             r_n;

  alu_core u_core (
    .i_a      (A),
    .i_b      (B),
    .i_op     (ALUControl),
    .o_result (w_result),
    .o_flags  (w_flags)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= '0;
      r_z      <= 1'b0;
      r_n      <= 1'b0;
    end else begin
      r_result <= w_result;
      r_z      <= w_flags.z;
      r_n      <= w_flags.n;
    end
  end

  assign Result = r_result;
  assign Z_flag = r_z;
  assign N_flag = r_n;

`ifdef ALU_CV_FLAGS_EN
  logic r_c;
  logic r_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_c <= 1'b0;
      r_v <= 1'b0;
    end else begin
      r_c <= w_flags.c;
      r_v <= w_flags.v;
    end
  end

  assign C_flag = r_c;
  assign V_flag = r_v;
`else
  assign C_flag = 1'b0;
  assign V_flag = 1'b0;
`endif

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: driver queues expected outputs,
// a monitor pops and compares one entry after each rising edge.
module tb_alu;
  import alu_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  ALUControl;
  logic [31:0] Result;
  logic        Z_flag;
  logic        N_flag;
  logic        C_flag;
  logic        V_flag;

  int errs;
  int checks;

  typedef struct {
    string       name;
    logic [31:0] r;
    logic        z;
    logic        n;
    logic        c;
    logic        v;
  } exp_t;

  exp_t sb[$];

  alu dut (
    .clk        (clk),
    .rst        (rst),
    .A          (A),
    .B          (B),
    .ALUControl (ALUControl),
    .Result     (Result),
    .Z_flag     (Z_flag),
    .N_flag     (N_flag),
    .C_flag     (C_flag),
    .V_flag     (V_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ALU_CV_FLAGS_EN
  localparam bit CV_ON = 1'b1;
`else
  localparam bit CV_ON = 1'b0;
`endif

  task automatic cmp(input exp_t e);
    checks++;
    if (Result !== e.r || Z_flag !== e.z ||
        N_flag !== e.n || C_flag !== e.c ||
        V_flag !== e.v) begin
      errs++;
      $display("FAIL %s: got R=%h Z%b N%b C%b V%b want R=%h Z%b N%b C%b V%b",
               e.name, Result, Z_flag, N_flag, C_flag, V_flag,
               e.r, e.z, e.n, e.c, e.v);
    end
  endtask

  // Monitor: one queued expectation per rising edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) cmp(sb.pop_front());
  end

  task automatic issue(
    input string       nm,
    input logic [3:0]  op,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] r,
    input logic        z,
    input logic        n,
    input logic        c,
    input logic        v
  );
    exp_t e;
    @(negedge clk);
    ALUControl = op;
    A = a;
    B = b;
    e.name = nm;
    e.r = r;
    e.z = z;
    e.n = n;
    e.c = c & CV_ON;
    e.v = v & CV_ON;
    sb.push_back(e);
  endtask

  task automatic chk_zero(input string nm);
    exp_t e;
    e.name = nm;
    e.r = '0;
    e.z = 1'b0;
    e.n = 1'b0;
    e.c = 1'b0;
    e.v = 1'b0;
    cmp(e);
  endtask

  initial begin
    exp_t e;
    errs = 0;
    checks = 0;
    rst = 1'b0;
    A = '0;
    B = '0;
    ALUControl = ALU_ADD;
    #1 rst = 1'b1;
    #1 chk_zero("reset_init");
    @(negedge clk);
    A = 32'd5;
    B = 32'd3;
    ALUControl = ALU_ADD;
    @(posedge clk);
    #1 chk_zero("reset_hold");
    @(negedge clk);
    rst = 1'b0;

    //       name        op        A             B             Result        Z     N     C     V
    issue("add",      ALU_ADD,  32'h00000005, 32'h00000003, 32'h00000008, 1'b0, 1'b0, 1'b0, 1'b0);
    issue("add0",     ALU_ADD,  32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0);
    issue("sub",      ALU_SUB,  32'h00000005, 32'h00000003, 32'h00000002, 1'b0, 1'b0, 1'b1, 1'b0);
    issue("sub_neg",  ALU_SUB,  32'h00000005, 32'h0000000A, 32'hFFFFFFFB, 1'b0, 1'b1, 1'b0, 1'b0);
    issue("sub_eq",   ALU_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0);
    issue("sub_ovf",  ALU_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 1'b1);
    issue("and",      ALU_AND,  32'h0000000F, 32'h000000F0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0);
    issue("or",       ALU_OR,   32'h0000000F, 32'h000000F0, 32'h000000FF, 1'b0, 1'b0, 1'b0, 1'b0);
    issue("xor",      ALU_XOR,  32'h000000FF, 32'h0000000F, 32'h000000F0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue("sll",      ALU_SLL,  32'h00000001, 32'h00000002, 32'h00000004, 1'b0, 1'b0, 1'b0, 1'b0);
    issue("sll_hiB",  ALU_SLL,  32'h00000001, 32'hFFFFFFE2, 32'h00000004, 1'b0, 1'b0, 1'b0, 1'b0);
    issue("srl",      ALU_SRL,  32'h00000010, 32'h00000002, 32'h00000004, 1'b0, 1'b0, 1'b0, 1'b0);
    issue("srl31",    ALU_SRL,  32'h80000000, 32'h0000001F, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0);
    issue("sra",      ALU_SRA,  32'h80000010, 32'h00000002, 32'hE0000004, 1'b0, 1'b1, 1'b0, 1'b0);
    issue("slt",      ALU_SLT,  32'h00000005, 32'h0000000A, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0);
    issue("sltu",     ALU_SLTU, 32'h00000005, 32'h0000000A, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0);
    issue("slt_m1",   ALU_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0);
    issue("sltu_m1",  ALU_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0);
    issue("slt_min",  ALU_SLT,  32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0);
    issue("slt_rev",  ALU_SLT,  32'h00000001, 32'h80000000, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0);
    issue("add_ovf",  ALU_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1);
    issue("add_cry",  ALU_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0);
    issue("undef_a",  4'b1010,  32'h00000005, 32'h00000003, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0);
    issue("undef_9",  4'b1001,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0);
    issue("add_big",  ALU_ADD,  32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b1);

    // Let the last queued entry be checked, then reset between edges.
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1 chk_zero("reset_mid");
    @(negedge clk);
    A = 32'h7FFFFFFF;
    B = 32'h00000001;
    ALUControl = ALU_ADD;
    @(posedge clk);
    #1 chk_zero("reset_discard");
    @(negedge clk);
    rst = 1'b0;
    e.name = "post_reset";
    e.r = 32'h80000000;
    e.z = 1'b0;
    e.n = 1'b1;
    e.c = 1'b0;
    e.v = CV_ON;
    sb.push_back(e);

    repeat (3) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      errs++;
      checks++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
